// File: rtl/dbu_btn_pkg.sv
// Shared types and constants for the debug-unit button conditioner.
// Optional auto-repeat is selected with the BTN_AUTOREPEAT_EN macro.
package dbu_btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } btn_state_e;

    localparam int BTN_CNT_W = 24;

    localparam int BTN_STEP = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_DEC  = 2;

endpackage

// File: rtl/dbu_btn_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and press FSM.
// With BTN_AUTOREPEAT_EN defined, a held button also emits periodic repeat pulses.
module dbu_btn_ch
    import dbu_btn_pkg::*;
#(
    parameter int unsigned DB_CNT  = 1_000_000,
    parameter int unsigned RPT_DLY = 50_000_000,
    parameter int unsigned RPT_PER = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic rpt_en,
    output logic level,
    output logic pulse
);

    localparam logic [BTN_CNT_W-1:0] CNT_TOP = BTN_CNT_W'(DB_CNT - 1);

    logic [1:0]           sync;
    logic                 s;
    logic [BTN_CNT_W-1:0] cnt;
    btn_state_e           state;

    assign s = sync[1];

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int          RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_TOP = RPT_W'(RPT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_TOP = RPT_W'(RPT_PER - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_rep;   // first repeat already issued: use the shorter period
`else
    localparam int unsigned unused_rpt_prm = RPT_DLY + RPT_PER;
    logic unused_rpt;
    assign unused_rpt = rpt_en;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears the synchroniser too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            state <= IDLE;
            level <= 1'b0;
            pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt <= '0;
            rpt_rep <= 1'b0;
`endif
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        cnt   <= '0;
                        state <= PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_TOP) begin
                        state <= HELD;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        cnt   <= '0;
                        state <= REL_CHK;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt <= '0;
                        rpt_rep <= 1'b0;
                    end else if (rpt_en) begin
                        if (rpt_cnt == (rpt_rep ? PER_TOP : DLY_TOP)) begin
                            pulse   <= 1'b1;
                            rpt_cnt <= '0;
                            rpt_rep <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
`endif
                    end
                end
                REL_CHK: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == CNT_TOP) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dbu_btn_cond.sv
// Button conditioner for the DBU step/inc/dec inputs: N_BTN independent channels.
// Define BTN_AUTOREPEAT_EN to enable per-channel auto-repeat gated by rpt_mask.
module dbu_btn_cond
    import dbu_btn_pkg::*;
#(
    parameter int          N_BTN   = 3,
    parameter int unsigned DB_CNT  = 1_000_000,
    parameter int unsigned RPT_DLY = 50_000_000,
    parameter int unsigned RPT_PER = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rpt_mask,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        dbu_btn_ch #(
            .DB_CNT  (DB_CNT),
            .RPT_DLY (RPT_DLY),
            .RPT_PER (RPT_PER)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn_raw[i]),
            .rpt_en (rpt_mask[i]),
            .level  (btn_level[i]),
            .pulse  (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_dbu_btn_cond.sv
// Self-checking bench for dbu_btn_cond: per-cycle vector table plus reset and repeat sequences.
// Repeat expectations follow BTN_AUTOREPEAT_EN when the macro is defined for the build.
module tb_dbu_btn_cond;
    import dbu_btn_pkg::*;

    localparam int N = 3;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] level;
        logic [N-1:0] pulse;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] rpt_mask = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    dbu_btn_cond #(
        .N_BTN   (N),
        .DB_CNT  (4),
        .RPT_DLY (20),
        .RPT_PER (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .rpt_mask  (rpt_mask),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] raw, input logic [N-1:0] lvl,
                       input logic [N-1:0] pls, input int n);
        vec_t v;
        v.raw   = raw;
        v.level = lvl;
        v.pulse = pls;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // 1: clean press on step, release six cycles after the fall
        add(3'b001, 3'b000, 3'b000, 6);
        add(3'b001, 3'b001, 3'b001, 1);
        add(3'b001, 3'b001, 3'b000, 13);
        add(3'b000, 3'b001, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 4);
        // 2: bounce 1,0,1,0 then steady high
        add(3'b001, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 1);
        add(3'b001, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 1);
        add(3'b001, 3'b000, 3'b000, 6);
        add(3'b001, 3'b001, 3'b001, 1);
        add(3'b001, 3'b001, 3'b000, 3);
        add(3'b000, 3'b001, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 4);
        // 3: short high glitch, then a short low glitch while held
        add(3'b001, 3'b000, 3'b000, 3);
        add(3'b000, 3'b000, 3'b000, 6);
        add(3'b001, 3'b000, 3'b000, 6);
        add(3'b001, 3'b001, 3'b001, 1);
        add(3'b001, 3'b001, 3'b000, 3);
        add(3'b000, 3'b001, 3'b000, 3);
        add(3'b001, 3'b001, 3'b000, 8);
        add(3'b000, 3'b001, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 4);
        // 4: inc and dec together, step untouched
        add(3'b110, 3'b000, 3'b000, 6);
        add(3'b110, 3'b110, 3'b110, 1);
        add(3'b110, 3'b110, 3'b000, 3);
        add(3'b000, 3'b110, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 4);

        // reset state
        repeat (3) tick();
        check("reset_level", btn_level, 3'b000);
        check("reset_pulse", btn_pulse, 3'b000);
        rst = 1'b1;
        repeat (2) tick();
        check("idle_level", btn_level, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].level);
            check($sformatf("vec%0d_pulse", i), btn_pulse, vecs[i].pulse);
        end

        // 5: reset while in PRESS_CHK with cnt=2, button kept held
        btn_raw = 3'b001;
        repeat (5) tick();
        check("pre_rst_level", btn_level, 3'b000);
        #2 rst = 1'b0;
        #1;
        check("rst_async_level", btn_level, 3'b000);
        check("rst_async_pulse", btn_pulse, 3'b000);
        repeat (2) tick();
        check("rst_hold_level", btn_level, 3'b000);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("post_rst%0d_pulse", i), btn_pulse, (i == 6) ? 3'b001 : 3'b000);
            check($sformatf("post_rst%0d_level", i), btn_level, (i >= 6) ? 3'b001 : 3'b000);
        end
        // reset while HELD clears the level without waiting for a clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_held_level", btn_level, 3'b000);
        btn_raw = 3'b000;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rst_rel%0d_level", i), btn_level, 3'b000);
            check($sformatf("rst_rel%0d_pulse", i), btn_pulse, 3'b000);
        end

        // 6: step and inc held 40 cycles, repeat enabled on inc/dec only
        rpt_mask = 3'b110;
        for (int v = 0; v < 50; v++) begin
            logic [N-1:0] exp_lvl;
            logic [N-1:0] exp_pls;
            btn_raw = (v < 40) ? 3'b011 : 3'b000;
            tick();
            exp_lvl = (v >= 6 && v < 46) ? 3'b011 : 3'b000;
            exp_pls = '0;
            exp_pls[BTN_STEP] = (v == 6);
            exp_pls[BTN_INC]  = (v == 6) ||
                                (RPT_ON && (v == 26 || v == 31 || v == 36 || v == 41));
            check($sformatf("rpt%0d_level", v), btn_level, exp_lvl);
            check($sformatf("rpt%0d_pulse", v), btn_pulse, exp_pls);
        end
        rpt_mask = 3'b000;
        repeat (3) tick();
        check("final_level", btn_level, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
